// File: rtl/sodor_mem_arbiter.sv
// sodor_mem_arbiter
// Shares one synchronous single-ported scratchpad RAM between the core's
// instruction-fetch port (imem) and its data port (dmem).
//
// Arbitration: data has fixed priority over fetch. A starvation counter
// tracks how many conflicts in a row fetch has lost. Once the count reaches
// STARVE_LIMIT, fetch is forced to win the next conflict.
//
// Every grant completes in one cycle. The response is a single-cycle pulse
// exactly one cycle after the grant, and there is no response backpressure.
// Misaligned or out-of-range requests are still granted, but they never touch
// the RAM; their response carries the error flag.
//
// Handshake: a request fires on a rising edge where valid && ready are both
// high. ready is a combinational function of both valids and the counter,
// so a master must not make valid depend on ready. At most one port fires
// per cycle.
//
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   imem_req_*                      fetch request (valid/ready/addr)
//   imem_resp_*                     fetch response (valid/data/err)
//   dmem_req_*                      data request (valid/ready/addr/wen/wdata/wmask)
//   dmem_resp_*                     data response (valid/data/err)
//   ram_en/we/addr/wdata/wmask      RAM command, combinational from the winner
//   ram_rdata                       RAM read data, valid the cycle after ram_en
module sodor_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_AW       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                imem_req_valid,
    output logic                imem_req_ready,
    input  logic [ADDR_W-1:0]   imem_req_addr,
    output logic                imem_resp_valid,
    output logic [DATA_W-1:0]   imem_resp_data,
    output logic                imem_resp_err,
    input  logic                dmem_req_valid,
    output logic                dmem_req_ready,
    input  logic [ADDR_W-1:0]   dmem_req_addr,
    input  logic                dmem_req_wen,
    input  logic [DATA_W-1:0]   dmem_req_wdata,
    input  logic [DATA_W/8-1:0] dmem_req_wmask,
    output logic                dmem_resp_valid,
    output logic [DATA_W-1:0]   dmem_resp_data,
    output logic                dmem_resp_err,
    output logic                ram_en,
    output logic                ram_we,
    output logic [MEM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wmask,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt;
    logic              force_i;
    logic              imem_fire;
    logic              dmem_fire;
    logic              any_fire;
    logic [ADDR_W-1:0] win_addr;
    logic              win_err;

    // Response stage
    logic resp_vld;
    logic resp_owner;   // 0 = imem, 1 = dmem
    logic resp_err;
    logic resp_isst;

    // Fetch wins a conflict only when it has already lost STARVE_LIMIT
    // conflicts in a row.
    assign force_i        = imem_req_valid && dmem_req_valid && (starve_cnt == CNT_MAX);
    assign dmem_req_ready = !force_i;
    assign imem_req_ready = !dmem_req_valid || force_i;

    // The ready terms are mutually exclusive whenever both valids are high,
    // so at most one of these fires in a cycle.
    assign imem_fire = imem_req_valid && imem_req_ready;
    assign dmem_fire = dmem_req_valid && dmem_req_ready;
    assign any_fire  = imem_fire || dmem_fire;

    assign win_addr = dmem_fire ? dmem_req_addr : imem_req_addr;
    // An address is in range only if all bits above the RAM's byte span are zero.
    assign win_err  = (win_addr[1:0] != 2'b00) || ((win_addr >> (MEM_AW + 2)) != '0);

    assign ram_en    = any_fire && !win_err;
    assign ram_we    = dmem_fire && dmem_req_wen;
    assign ram_addr  = win_addr[MEM_AW+1:2];
    assign ram_wdata = dmem_req_wdata;
    assign ram_wmask = ram_we ? dmem_req_wmask : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!imem_req_valid || imem_fire) begin
            starve_cnt <= '0;
        end else if (dmem_fire && (starve_cnt != CNT_MAX)) begin
            // imem is valid here, so a dmem fire means fetch lost a conflict.
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_vld   <= 1'b0;
            resp_owner <= 1'b0;
            resp_err   <= 1'b0;
            resp_isst  <= 1'b0;
        end else begin
            resp_vld   <= any_fire;
            resp_owner <= dmem_fire;
            resp_err   <= any_fire && win_err;
            resp_isst  <= dmem_fire && dmem_req_wen;
        end
    end

    // The RAM returns read data one cycle after ram_en, which lines up with
    // the response stage. Stores and errors return zero data.
    assign imem_resp_valid = resp_vld && !resp_owner;
    assign imem_resp_err   = imem_resp_valid && resp_err;
    assign imem_resp_data  = (imem_resp_valid && !resp_err) ? ram_rdata : '0;

    assign dmem_resp_valid = resp_vld && resp_owner;
    assign dmem_resp_err   = dmem_resp_valid && resp_err;
    assign dmem_resp_data  = (dmem_resp_valid && !resp_err && !resp_isst) ? ram_rdata : '0;

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
module tb_sodor_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_wmask;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        dmem_resp_err;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_rdata;

  int tests = 0;
  int fails = 0;

  // {err, data}
  logic [32:0] imem_exp_q[$];
  logic [32:0] dmem_exp_q[$];

  sodor_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_AW(14), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .dmem_resp_err(dmem_resp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- RAM model ----------------
  // Synchronous single-port RAM. Preload pattern: word i = 0xA000_0000 | i,
  // except word 2 = 0xDEADBEEF. It is reloaded while reset is held.
  logic [31:0] mem [0:16383];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[2] <= 32'hDEAD_BEEF;
      ram_rdata <= 32'h0;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (imem_resp_valid) begin
      if (imem_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL imem_resp_unexpected: got err=%0b data=0x%0h expected no response at %0t",
                 imem_resp_err, imem_resp_data, $time);
      end else begin
        chk("imem_resp", {31'b0, imem_resp_err, imem_resp_data}, {31'b0, imem_exp_q.pop_front()});
      end
    end
    if (dmem_resp_valid) begin
      if (dmem_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL dmem_resp_unexpected: got err=%0b data=0x%0h expected no response at %0t",
                 dmem_resp_err, dmem_resp_data, $time);
      end else begin
        chk("dmem_resp", {31'b0, dmem_resp_err, dmem_resp_data}, {31'b0, dmem_exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. Drives one cycle of requests, checks the
  // combinational grant outputs at the falling edge, queues the expected
  // responses for the ports that are expected to fire, and returns just after
  // the next rising edge.
  task automatic step(input logic iv, input logic [31:0] ia,
                      input logic dv, input logic [31:0] da, input logic dw,
                      input logic [31:0] dwd, input logic [3:0] dwm,
                      input logic e_ir, input logic e_dr, input logic e_en,
                      input logic [13:0] e_ad,
                      input logic [32:0] e_iresp, input logic [32:0] e_dresp,
                      input logic push);
    logic e_we;
    imem_req_valid = iv;
    imem_req_addr  = ia;
    dmem_req_valid = dv;
    dmem_req_addr  = da;
    dmem_req_wen   = dw;
    dmem_req_wdata = dwd;
    dmem_req_wmask = dwm;
    e_we = dv && e_dr && dw;
    @(negedge clock);
    chk("imem_req_ready", 64'(imem_req_ready), 64'(e_ir));
    chk("dmem_req_ready", 64'(dmem_req_ready), 64'(e_dr));
    chk("ram_en", 64'(ram_en), 64'(e_en));
    chk("ram_we", 64'(ram_we), 64'(e_we));
    chk("ram_wmask", 64'(ram_wmask), e_we ? 64'(dwm) : 64'h0);
    if (e_en) chk("ram_addr", 64'(ram_addr), 64'(e_ad));
    if (e_en && e_we) chk("ram_wdata", 64'(ram_wdata), 64'(dwd));
    if (push && iv && e_ir) imem_exp_q.push_back(e_iresp);
    if (push && dv && e_dr) dmem_exp_q.push_back(e_dresp);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b0, 14'h0, 33'h0, 33'h0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    imem_req_valid = 1'b0;
    imem_req_addr  = 32'h0;
    dmem_req_valid = 1'b0;
    dmem_req_addr  = 32'h0;
    dmem_req_wen   = 1'b0;
    dmem_req_wdata = 32'h0;
    dmem_req_wmask = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_imem_resp_valid", 64'(imem_resp_valid), 64'h0);
    chk("rst_dmem_resp_valid", 64'(dmem_resp_valid), 64'h0);
    chk("rst_imem_resp_err", 64'(imem_resp_err), 64'h0);
    chk("rst_dmem_resp_err", 64'(dmem_resp_err), 64'h0);
    chk("rst_imem_resp_data", 64'(imem_resp_data), 64'h0);
    chk("rst_dmem_resp_data", 64'(dmem_resp_data), 64'h0);
    chk("rst_ram_en", 64'(ram_en), 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single fetch of word 2
    step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd2, {1'b0, 32'hDEAD_BEEF}, 33'h0, 1'b1);
    idle();

    // Store then load of word 4 on consecutive edges
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h1234_5678, 4'hF,
         1'b0, 1'b1, 1'b1, 14'd4, 33'h0, {1'b0, 32'h0}, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0, 4'h0,
         1'b0, 1'b1, 1'b1, 14'd4, 33'h0, {1'b0, 32'h1234_5678}, 1'b1);
    // Partial-mask store: only byte 0 changes
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hFFFF_FF9A, 4'h1,
         1'b0, 1'b1, 1'b1, 14'd4, 33'h0, {1'b0, 32'h0}, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0, 4'h0,
         1'b0, 1'b1, 1'b1, 14'd4, 33'h0, {1'b0, 32'h1234_569A}, 1'b1);

    // Contention: fetch word 3 vs load word 5, both held for 6 cycles
    for (int c = 0; c < 6; c++) begin
      if (c == 4)
        step(1'b1, 32'hC, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0,
             1'b1, 1'b0, 1'b1, 14'd3, {1'b0, 32'hA000_0003}, 33'h0, 1'b1);
      else
        step(1'b1, 32'hC, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0,
             1'b0, 1'b1, 1'b1, 14'd5, 33'h0, {1'b0, 32'hA000_0005}, 1'b1);
    end
    idle();

    // Errors: misaligned fetch, out-of-range store, then prove word 0 untouched
    step(1'b1, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b0, 14'h0, {1'b1, 32'h0}, 33'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h0001_0000, 1'b1, 32'h5555_AAAA, 4'hF,
         1'b0, 1'b1, 1'b0, 14'h0, 33'h0, {1'b1, 32'h0}, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b0, 1'b1, 1'b1, 14'd0, 33'h0, {1'b0, 32'hA000_0000}, 1'b1);
    idle();

    // Reset mid-flight: the pending fetch response must be dropped
    step(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd1, 33'h0, 33'h0, 1'b0);
    imem_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_imem_resp_valid", 64'(imem_resp_valid), 64'h0);
    chk("midrst_starve_cnt", 64'(dut.starve_cnt), 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd2, {1'b0, 32'hDEAD_BEEF}, 33'h0, 1'b1);
    idle();

    // Pipelining: fetches of words 0, 1, 2 back to back
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd0, {1'b0, 32'hA000_0000}, 33'h0, 1'b1);
    step(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd1, {1'b0, 32'hA000_0001}, 33'h0, 1'b1);
    step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
         1'b1, 1'b1, 1'b1, 14'd2, {1'b0, 32'hDEAD_BEEF}, 33'h0, 1'b1);
    repeat (3) idle();

    // Every queued response must have been delivered
    chk("imem_exp_q_drained", 64'(imem_exp_q.size()), 64'h0);
    chk("dmem_exp_q_drained", 64'(dmem_exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sodor_mem_arbiter.md
# sodor_mem_arbiter

Single-port memory arbiter for the Sodor tile scratchpad. It shares one synchronous single-ported RAM (the text/data memory the bench preloads) between the core's instruction-fetch port and its data port. Arbitration is fixed priority (data over fetch) with a starvation guard. Accesses are fully pipelined: one grant per cycle, and the response arrives exactly one cycle after the grant. Requests that are misaligned or out of range are answered with an error flag and never touch the RAM.

## Interface
- ADDR_W, 32, request address width (byte address)
- DATA_W, 32, data width; DATA_W/8 mask bits
- MEM_AW, 14, RAM word-index width (RAM holds 2^MEM_AW words)
- STARVE_LIMIT, 4, consecutive lost conflicts tolerated by fetch before it is forced to win (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  in  1  fetch request
- imem_req_ready  out  1  fetch request accepted this cycle
- imem_req_addr  in  ADDR_W  fetch byte address
- imem_resp_valid  out  1  fetch response (single-cycle pulse, no backpressure)
- imem_resp_data  out  DATA_W  fetch read data
- imem_resp_err  out  1  fetch misaligned/out of range
- dmem_req_valid  in  1  data request
- dmem_req_ready  out  1  data request accepted this cycle
- dmem_req_addr  in  ADDR_W  data byte address
- dmem_req_wen  in  1  1 = store, 0 = load
- dmem_req_wdata  in  DATA_W  store data
- dmem_req_wmask  in  DATA_W/8  store byte enables
- dmem_resp_valid  out  1  data response pulse (loads and stores)
- dmem_resp_data  out  DATA_W  load data; 0 for stores and errors
- dmem_resp_err  out  1  data misaligned/out of range
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_addr  out  MEM_AW  RAM word index
- ram_wdata  out  DATA_W  RAM write data
- ram_wmask  out  DATA_W/8  RAM byte enables
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

## Operation
- Fire: a request fires when valid && ready at a rising edge.
- Ready logic (combinational from the valids and the counter):
  - force_i = imem_req_valid && dmem_req_valid && (starve_cnt == STARVE_LIMIT)
  - dmem_req_ready = !force_i
  - imem_req_ready = !dmem_req_valid || force_i
- Starvation counter starve_cnt has width clog2(STARVE_LIMIT+1), reset value 0:
  - increments, saturating at STARVE_LIMIT, on each cycle where both valids are high and dmem fires
  - clears to 0 on an imem fire, or on any cycle where imem_req_valid is low
- Error check, performed on the winning request:
  - err = addr[1:0] != 0, or addr[ADDR_W-1:MEM_AW+2] != 0
  - An erroring request still fires, but drives ram_en = 0.
- RAM drive, combinational from the winner:
  - ram_en = fire && !err
  - ram_we = winner is dmem && dmem_req_wen
  - ram_addr = addr[MEM_AW+1:2]
  - ram_wdata and ram_wmask pass through from the dmem request; ram_wmask = 0 when ram_we = 0
- Response stage registers: resp_vld, resp_owner (0 = imem, 1 = dmem), resp_err, resp_isst.
  - x_resp_valid = resp_vld && owner match
  - data output = ram_rdata for a non-error load/fetch; 0 for stores and errors
- No internal state machine beyond the response register and the counter; every grant completes in one cycle.

## Timing
- Reset (asynchronous on reset_n low):
  - resp_vld, resp_owner, resp_err, resp_isst and starve_cnt go to 0.
  - Hence imem_resp_valid = dmem_resp_valid = 0, both err outputs = 0, both resp_data = 0.
  - ram_en = 0 while no valid is high.
  - Reset deassertion needs no synchronizer inside the block; the caller synchronizes it.
- Latency: fire at edge N produces the response valid during cycle N+1, for exactly one cycle.
- Throughput: one fire per cycle. Back-to-back fires give back-to-back responses.
- Read-after-write: a dmem store at edge N followed by a load of the same word at edge N+1 returns the new data. This relies on the RAM's write-then-read ordering across cycles; no bypass is implemented.
- Simultaneous valids: dmem wins, except when starve_cnt == STARVE_LIMIT, in which case imem wins and the counter clears.
- Reset mid-operation: a response pending at reset assertion is dropped and is never emitted.

## Test plan
- Single fetch: imem addr 0x8, RAM word 2 = 0xDEADBEEF -> ram_en/ram_addr=2 at grant; imem_resp_valid=1, data 0xDEADBEEF, err=0 one cycle later.
- Store then load: dmem store 0x10, wdata 0x12345678, mask 0xF; next cycle load 0x10 -> store resp data 0, err 0; load resp data 0x12345678.
- Contention with STARVE_LIMIT=4: both valids held high 6 cycles -> dmem granted cycles 0-3, imem granted cycle 4 (counter clears), dmem granted cycle 5.
- Errors: imem addr 0x2 -> ram_en=0, imem_resp_err=1, data 0. dmem addr 0x0001_0000 with MEM_AW=14 -> dmem_resp_err=1, no RAM write.
- Reset mid-flight: reset_n low in the cycle after an imem fire -> imem_resp_valid stays 0, starve_cnt=0. After release, the next fetch completes normally.
- Pipelining: imem fires at 0x0, 0x4, 0x8 on consecutive edges with dmem idle -> three consecutive resp pulses with words 0, 1, 2 in order.
